tcache_refill_ctrl: RTL

//  Miss handler between the per-port tcaches and the main TLB. Arbitrates tcache misses

---
 rtl/tcache_refill_ctrl_pkg.sv | 45 ++++
 rtl/tcache_refill_ctrl_if.sv | 31 +++
 rtl/tcache_refill_ctrl_rr_arbiter.sv | 27 ++
 rtl/tcache_refill_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/tcache_refill_ctrl_pkg.sv
// rtl/tcache_refill_ctrl_pkg.sv - shared TLB types and refill FSM encoding for the tcache refill controller
package tcache_refill_ctrl_pkg;

  localparam int TLBIDLEN = 4;
  localparam int VPPN_W   = 19;
  localparam int ASID_W   = 10;

  // Main TLB entry: common part followed by the even and odd page halves.
  typedef struct packed {
    logic              e;
    logic [ASID_W-1:0] asid;
    logic              g;
    logic [5:0]        ps;
    logic [VPPN_W-1:0] vppn;
    logic              v0;
    logic              d0;
    logic [1:0]        mat0;
    logic [1:0]        plv0;
    logic [19:0]       ppn0;
    logic              v1;
    logic              d1;
    logic [1:0]        mat1;
    logic [1:0]        plv1;
    logic [19:0]       ppn1;
  } tlb_entry_t;

  typedef struct packed {
    logic                found;
    logic [TLBIDLEN-1:0] index;
  } tlb_result_t;

  typedef enum logic [1:0] {
    RF_IDLE,
    RF_LOOKUP,
    RF_READ,
    RF_RESP
  } refill_state_t;

  typedef struct packed {
    logic [VPPN_W-1:0] vppn;
    logic              va_bit12;
    logic [ASID_W-1:0] asid;
  } tcache_req_t;

endpackage

// File: rtl/tcache_refill_ctrl_if.sv
// rtl/tcache_refill_ctrl_if.sv - tcache-side miss request / refill / response bundle
interface tcache_refill_ctrl_if
  import tcache_refill_ctrl_pkg::*;
#(
  parameter int NREQ = 2
);

  logic [NREQ-1:0]             req_valid;
  logic [NREQ-1:0][VPPN_W-1:0] req_vppn;
  logic [NREQ-1:0]             req_va_bit12;
  logic [NREQ-1:0][ASID_W-1:0] req_asid;
  logic [NREQ-1:0]             req_grant;
  logic [NREQ-1:0]             refill_valid;
  tlb_entry_t                  refill_data;
  logic [TLBIDLEN-1:0]         refill_index;
  logic [NREQ-1:0]             resp_valid;
  logic                        resp_found;

  // tcache side: raises misses, receives refills and responses
  modport master (
    output req_valid, req_vppn, req_va_bit12, req_asid,
    input  req_grant, refill_valid, refill_data, refill_index, resp_valid, resp_found
  );

  // refill controller side
  modport slave (
    input  req_valid, req_vppn, req_va_bit12, req_asid,
    output req_grant, refill_valid, refill_data, refill_index, resp_valid, resp_found
  );

endinterface

// File: rtl/tcache_refill_ctrl_rr_arbiter.sv
// rtl/tcache_refill_ctrl_rr_arbiter.sv - one-hot arbiter scanning upward from a start pointer
module rr_arbiter #(
  parameter int NREQ  = 2,
  parameter int PTR_W = 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  grant
);

  // first requester at or after ptr (wrapping) wins
  always_comb begin
    logic found;
    int   idx;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int off = 0; off < NREQ; off++) begin
      idx = (int'(ptr) + off) % NREQ;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tcache_refill_ctrl.sv
// rtl/tcache_refill_ctrl.sv - tcache miss handler: arbitrate, search/read main TLB, refill; perf counters under TCACHE_REFILL_PERF_EN
module tcache_refill_ctrl
  import tcache_refill_ctrl_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int ARB_RR = 1,
  parameter int CNT_W  = 32
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       flush,
  tcache_refill_ctrl_if.slave        tc,
  output logic [VPPN_W-1:0]          tlb_s_vppn,
  output logic                       tlb_s_va_bit12,
  output logic [ASID_W-1:0]          tlb_s_asid,
  input  tlb_result_t                tlb_s_result,
  output logic [TLBIDLEN-1:0]        tlb_r_index,
  input  tlb_entry_t                 tlb_r_entry
`ifdef TCACHE_REFILL_PERF_EN
  ,
  output logic [NREQ-1:0][CNT_W-1:0] perf_miss_cnt,
  output logic [NREQ-1:0][CNT_W-1:0] perf_fault_cnt
`endif
);

  localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  refill_state_t       state_q, state_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  tcache_req_t         req_q, req_d;
  logic                found_q, found_d;
  logic [TLBIDLEN-1:0] index_q, index_d;
  tlb_entry_t          entry_q, entry_d;

  logic [NREQ-1:0]     arb_grant;
  logic [ID_W-1:0]     arb_id;
  logic [ID_W-1:0]     arb_ptr;
  logic [NREQ-1:0]     grant;
  logic [NREQ-1:0]     refill_v;
  logic [NREQ-1:0]     resp_v;
  logic                resp_found_o;

  assign arb_ptr = (ARB_RR != 0) ? ptr_q : '0;

  rr_arbiter #(
    .NREQ  (NREQ),
    .PTR_W (ID_W)
  ) u_arb (
    .req   (tc.req_valid),
    .ptr   (arb_ptr),
    .grant (arb_grant)
  );

  // binary id of the arbitration winner
  always_comb begin
    arb_id = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_grant[i]) arb_id = ID_W'(i);
    end
  end

  // next-state and output decode; flush overrides everything the FSM would do this cycle
  always_comb begin
    state_d      = state_q;
    id_d         = id_q;
    ptr_d        = ptr_q;
    req_d        = req_q;
    found_d      = found_q;
    index_d      = index_q;
    entry_d      = entry_q;
    grant        = '0;
    refill_v     = '0;
    resp_v       = '0;
    resp_found_o = 1'b0;
    case (state_q)
      RF_IDLE: begin
        if (|tc.req_valid) begin
          grant   = arb_grant;
          id_d    = arb_id;
          req_d   = '{vppn:     tc.req_vppn[arb_id],
                      va_bit12: tc.req_va_bit12[arb_id],
                      asid:     tc.req_asid[arb_id]};
          state_d = RF_LOOKUP;
        end
      end
      RF_LOOKUP: begin
        found_d = tlb_s_result.found;
        index_d = tlb_s_result.index;
        state_d = tlb_s_result.found ? RF_READ : RF_RESP;
      end
      RF_READ: begin
        entry_d = tlb_r_entry;
        state_d = RF_RESP;
      end
      RF_RESP: begin
        resp_v[id_q]   = 1'b1;
        refill_v[id_q] = found_q;
        resp_found_o   = found_q;
        ptr_d          = (id_q == ID_W'(NREQ - 1)) ? '0 : id_q + 1'b1;
        state_d        = RF_IDLE;
      end
      default: state_d = RF_IDLE;
    endcase
    if (flush) begin
      state_d      = RF_IDLE;
      id_d         = id_q;
      req_d        = req_q;
      ptr_d        = ptr_q;
      grant        = '0;
      refill_v     = '0;
      resp_v       = '0;
      resp_found_o = 1'b0;
    end
  end

  // state and captured miss context
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= RF_IDLE;
      id_q    <= '0;
      ptr_q   <= '0;
      req_q   <= '0;
      found_q <= 1'b0;
      index_q <= '0;
      entry_q <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      req_q   <= req_d;
      found_q <= found_d;
      index_q <= index_d;
      entry_q <= entry_d;
    end
  end

  // grant is combinational from req_valid, so it is also masked while reset is held
  assign tc.req_grant    = resetn ? grant : '0;
  assign tc.refill_valid = refill_v;
  assign tc.refill_data  = entry_q;
  assign tc.refill_index = index_q;
  assign tc.resp_valid   = resp_v;
  assign tc.resp_found   = resp_found_o;

  assign tlb_s_vppn      = req_q.vppn;
  assign tlb_s_va_bit12  = req_q.va_bit12;
  assign tlb_s_asid      = req_q.asid;
  assign tlb_r_index     = index_q;

`ifdef TCACHE_REFILL_PERF_EN
  logic [NREQ-1:0][CNT_W-1:0] miss_cnt_q, miss_cnt_d;
  logic [NREQ-1:0][CNT_W-1:0] fault_cnt_q, fault_cnt_d;

  // saturating per-requester miss (grant) and fault (not-found response) counts
  always_comb begin
    miss_cnt_d  = miss_cnt_q;
    fault_cnt_d = fault_cnt_q;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i] && (miss_cnt_q[i] != '1)) begin
        miss_cnt_d[i] = miss_cnt_q[i] + 1'b1;
      end
      if (resp_v[i] && !resp_found_o && (fault_cnt_q[i] != '1)) begin
        fault_cnt_d[i] = fault_cnt_q[i] + 1'b1;
      end
    end
  end

  // counter registers, cleared by reset only
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      miss_cnt_q  <= '0;
      fault_cnt_q <= '0;
    end else begin
      miss_cnt_q  <= miss_cnt_d;
      fault_cnt_q <= fault_cnt_d;
    end
  end

  assign perf_miss_cnt  = miss_cnt_q;
  assign perf_fault_cnt = fault_cnt_q;
`endif

endmodule
